dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Arbitrates the single data_mem port between the core load/store path and a host loader
//  (test-bench / DMA), which preloads operands and reads back results around program runs.
//  Sits between TopLevel's load/store datapath and data_mem: requester address/data in,
//  muxed memory port out. A refused grant is the core's stall signal.
//  Round-robin on conflict, optional host burst lock bounded by a fairness limit.
// PARAMETERS
//  AW        8   address width (data_mem index)
//  DW        8   data width
//  MAX_LOCK  16  max consecutive locked host grants before one core grant is forced
// PORTS
//  CLK          in   1   clock, posedge
//  reset_n      in   1   asynchronous, active-low reset
//  core_req     in   1   core access request (load or store)
//  core_we      in   1   1 = store, 0 = load
//  core_addr    in   AW  core address
//  core_wdata   in   DW  core store data
//  core_gnt     out  1   core granted this cycle (0 while core_req=1 => stall)
//  core_rvalid  out  1   core load data valid (1 cycle after load grant)
//  core_rdata   out  DW  registered load data
//  host_req / host_we / host_addr / host_wdata   in   as core_*
//  host_lock    in   1   hold grant across back-to-back host requests
//  host_gnt / host_rvalid / host_rdata           out  as core_*
//  mem_addr     out  AW  to data_mem DataAddress
//  mem_we       out  1   to data_mem WriteMem
//  mem_wdata    out  DW  to data_mem DataIn
//  mem_rdata    in   DW  from data_mem DataOut (combinational read)
//  conflict_ct  out  16  conflict cycles (only with DMEM_ARB_PERF_EN)
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=ARB_RR, last_gnt=HOST, lock_cnt=0, rvalid/rdata=0.
//    gnt/mem_* are combinational on req+state; with no req: gnt=0, mem_we=0, addr/wdata=0.
//  - At most one gnt per cycle; gnt only when the matching req=1. mem_* follow the winner.
//  - mem_we = winner_we & (core_gnt|host_gnt); never 1 without a grant.
//  - Load grant in cycle N: mem_rdata captured at edge ending N; rvalid=1 for cycle N+1 only.
//    Store grant: no rvalid. rdata holds value until next load of same requester.
//  - FSM ARB_RR: single req -> granted. Both -> grant the one != last_gnt; update last_gnt.
//    Host granted with host_lock=1 -> ARB_LOCK, lock_cnt=1.
//  - FSM ARB_LOCK: host wins every cycle it requests; lock_cnt++ per host grant.
//    host_lock=0 or host_req=0 -> ARB_RR (same-cycle arbitration uses RR rules).
//    lock_cnt==MAX_LOCK and core_req=1 -> grant core one cycle, lock_cnt=0, stay ARB_LOCK.
//    lock_cnt saturates at MAX_LOCK when core idle.
//  - Core never waits > MAX_LOCK+1 cycles with core_req held.
//  - Same-address conflict: the winner goes first; store by winner visible to loser's later load.
//  - Requester must hold req/we/addr/wdata stable until gnt; dropping req before gnt is legal.
//  - Reset mid-access: pending rvalid squashed, lock released.
// CONFIGURATION
//  DMEM_ARB_PERF_EN defined: conflict_ct counts cycles with core_req&host_req (saturating
//    at 16'hFFFF, cleared by reset). Undefined: port remains, tied to 0, no counter flops.
// STRUCTURE
//  dmem_arb_pkg: typedef enum logic {REQ_CORE, REQ_HOST} req_id_t;
//    typedef enum logic {ARB_RR, ARB_LOCK} arb_state_t; default AW/DW localparams.
//  Sub-module rd_return (one instance per requester): capture + rvalid pulse register.
//  Top holds FSM, last_gnt, lock_cnt, grant logic, mem mux, optional perf counter.
// TESTING
//  1 Core only: store 8'h5A @0x10, load @0x10 -> core_gnt same cycle, rvalid next, rdata 5A.
//  2 Both req every cycle from reset, no lock -> grants alternate core,host,core,...;
//    conflict_ct = cycles (PERF_EN).
//  3 Host lock=1, 40 back-to-back stores, core_req held -> core granted at lock_cnt=16,
//    twice total, 16 host grants between.
//  4 Host store 8'hA5 @0x20 wins conflict with core load @0x20 -> core rdata A5.
//  5 reset_n low mid ARB_LOCK with pending load -> no rvalid, outputs 0, state ARB_RR.
//  6 Assert every cycle: !(core_gnt&host_gnt), mem_we -> gnt, gnt -> req.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned AW_DEF       = 8;
    localparam int unsigned DW_DEF       = 8;
    localparam int unsigned MAX_LOCK_DEF = 16;
    localparam int unsigned CT_W         = 16;

    typedef enum logic {REQ_CORE = 1'b0, REQ_HOST = 1'b1} req_id_t;
    typedef enum logic {ARB_RR = 1'b0, ARB_LOCK = 1'b1} arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rd_return.sv
// Per-requester load return: captures memory data on a load grant and pulses rvalid once.
module rd_return
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    output logic          o_rvalid,
    output logic [DW-1:0] o_rdata
);

    logic          r_rvalid;
    logic [DW-1:0] r_rdata;

    // rdata holds until the next load of this requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= i_load;
            if (i_load) begin
                r_rdata <= i_data;
            end
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single data_mem port: round-robin with bounded host burst lock.
// Optional conflict-cycle counter enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [AW-1:0]   core_addr,
    input  logic [DW-1:0]   core_wdata,
    output logic            core_gnt,
    output logic            core_rvalid,
    output logic [DW-1:0]   core_rdata,
    input  logic            host_req,
    input  logic            host_we,
    input  logic [AW-1:0]   host_addr,
    input  logic [DW-1:0]   host_wdata,
    input  logic            host_lock,
    output logic            host_gnt,
    output logic            host_rvalid,
    output logic [DW-1:0]   host_rdata,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic [CT_W-1:0] conflict_ct
);

    localparam int unsigned    LW       = $clog2(MAX_LOCK + 1);
    localparam logic [LW-1:0]  LOCK_MAX = LW'(MAX_LOCK);

    arb_state_t    r_state;
    req_id_t       r_last_gnt;
    logic [LW-1:0] r_lock_cnt;

    logic w_lock_hold;
    logic w_core_gnt;
    logic w_host_gnt;

    // Grant decision: locked host burst wins unless the fairness slot is due
    always_comb begin
        w_lock_hold = (r_state == ARB_LOCK) && host_req && host_lock;
        w_core_gnt  = 1'b0;
        w_host_gnt  = 1'b0;
        if (w_lock_hold) begin
            if (core_req && (r_lock_cnt == LOCK_MAX)) begin
                w_core_gnt = 1'b1;
            end else begin
                w_host_gnt = 1'b1;
            end
        end else if (core_req && host_req) begin
            if (r_last_gnt == REQ_CORE) begin
                w_host_gnt = 1'b1;
            end else begin
                w_core_gnt = 1'b1;
            end
        end else begin
            w_core_gnt = core_req;
            w_host_gnt = host_req;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (w_core_gnt) begin
            mem_addr  = core_addr;
            mem_we    = core_we;
            mem_wdata = core_wdata;
        end else if (w_host_gnt) begin
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_wdata = host_wdata;
        end
    end

    assign core_gnt = w_core_gnt;
    assign host_gnt = w_host_gnt;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ARB_RR;
            r_last_gnt <= REQ_HOST;
            r_lock_cnt <= '0;
        end else begin
            if (w_core_gnt) begin
                r_last_gnt <= REQ_CORE;
            end else if (w_host_gnt) begin
                r_last_gnt <= REQ_HOST;
            end
            if (!(host_req && host_lock)) begin
                r_state    <= ARB_RR;
                r_lock_cnt <= '0;
            end else if (w_host_gnt) begin
                r_state <= ARB_LOCK;
                if (r_state == ARB_RR) begin
                    r_lock_cnt <= LW'(1);
                end else if (r_lock_cnt != LOCK_MAX) begin
                    r_lock_cnt <= r_lock_cnt + LW'(1);
                end
            end else if (w_core_gnt && (r_state == ARB_LOCK)) begin
                r_lock_cnt <= '0;
            end
        end
    end

    rd_return #(.DW(DW)) u_core_ret (
        .clk      (CLK),
        .rst_n    (reset_n),
        .i_load   (w_core_gnt && !core_we),
        .i_data   (mem_rdata),
        .o_rvalid (core_rvalid),
        .o_rdata  (core_rdata)
    );

    rd_return #(.DW(DW)) u_host_ret (
        .clk      (CLK),
        .rst_n    (reset_n),
        .i_load   (w_host_gnt && !host_we),
        .i_data   (mem_rdata),
        .o_rvalid (host_rvalid),
        .o_rdata  (host_rdata)
    );

`ifdef DMEM_ARB_PERF_EN
    logic [CT_W-1:0] r_conflict_ct;

    // Saturating count of cycles where both requesters ask at once
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_conflict_ct <= '0;
        end else if (core_req && host_req && (r_conflict_ct != '1)) begin
            r_conflict_ct <= r_conflict_ct + CT_W'(1);
        end
    end

    assign conflict_ct = r_conflict_ct;
`else
    assign conflict_ct = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a burst/fairness model.
module tb_dmem_arbiter;

    localparam int MAX_LOCK = 16;

    bit          CLK;
    logic        reset_n;
    logic        core_req, core_we, host_req, host_we, host_lock;
    logic [7:0]  core_addr, core_wdata, host_addr, host_wdata;
    logic        core_gnt, core_rvalid, host_gnt, host_rvalid, mem_we;
    logic [7:0]  core_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] conflict_ct;

    bit [7:0] env_mem [256];
    bit [7:0] ref_mem [256];

    int checks, failures;
    int m_last, m_streak, m_conf, core_wait;
    bit m_locked, m_crv, m_hrv;
    logic [7:0] m_crd, m_hrd;
    bit g_core, g_host;

    dmem_arbiter dut (
        .CLK(CLK), .reset_n(reset_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_ct(conflict_ct)
    );

    always #5 CLK = ~CLK;

    assign mem_rdata = env_mem[mem_addr];
    always @(posedge CLK) if (mem_we) env_mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 2; m_streak = 0; m_locked = 0; m_conf = 0; core_wait = 0;
        m_crv = 0; m_hrv = 0; m_crd = 8'h00; m_hrd = 8'h00;
    endtask

    task automatic set_idle();
        core_req = 0; core_we = 0; core_addr = 8'h00; core_wdata = 8'h00;
        host_req = 0; host_we = 0; host_addr = 8'h00; host_wdata = 8'h00; host_lock = 0;
    endtask

    // 0 = nobody, 1 = core, 2 = host; a host burst yields one slot after MAX_LOCK grants
    function automatic int model_winner();
        if (core_req && host_req) begin
            if (m_locked && host_lock) return (m_streak >= MAX_LOCK) ? 1 : 2;
            return (m_last == 1) ? 2 : 1;
        end
        if (core_req) return 1;
        if (host_req) return 2;
        return 0;
    endfunction

    // One clock: check at negedge, advance the model, return at posedge+1
    task automatic run_cycle();
        int w;
        int exp_conf;
        @(negedge CLK);
        w = model_winner();
`ifdef DMEM_ARB_PERF_EN
        exp_conf = m_conf;
`else
        exp_conf = 0;
`endif
        chk("core_gnt", 32'(core_gnt), 32'(w == 1));
        chk("host_gnt", 32'(host_gnt), 32'(w == 2));
        chk("mem_we", 32'(mem_we), 32'((w == 1) ? core_we : (w == 2) ? host_we : 1'b0));
        chk("mem_addr", 32'(mem_addr), 32'((w == 1) ? core_addr : (w == 2) ? host_addr : 8'h00));
        chk("mem_wdata", 32'(mem_wdata), 32'((w == 1) ? core_wdata : (w == 2) ? host_wdata : 8'h00));
        chk("core_rvalid", 32'(core_rvalid), 32'(m_crv));
        chk("core_rdata", 32'(core_rdata), 32'(m_crd));
        chk("host_rvalid", 32'(host_rvalid), 32'(m_hrv));
        chk("host_rdata", 32'(host_rdata), 32'(m_hrd));
        chk("conflict_ct", 32'(conflict_ct), 32'(exp_conf));
        chk("gnt_rules", 32'(!(core_gnt && host_gnt) && (!mem_we || core_gnt || host_gnt)
                             && (!core_gnt || core_req) && (!host_gnt || host_req)), 32'(1));
        g_core = core_gnt;
        g_host = host_gnt;
        if (core_gnt) begin
            chk("core_wait", 32'(core_wait <= MAX_LOCK + 1), 32'(1));
            core_wait = 0;
        end else if (core_req) core_wait++;
        else core_wait = 0;
        // model update for the edge ending this cycle
        m_crv = (w == 1) && !core_we;
        m_hrv = (w == 2) && !host_we;
        if (m_crv) m_crd = ref_mem[core_addr];
        if (m_hrv) m_hrd = ref_mem[host_addr];
        if (w == 1 && core_we) ref_mem[core_addr] = core_wdata;
        if (w == 2 && host_we) ref_mem[host_addr] = host_wdata;
        if (core_req && host_req && m_conf < 65535) m_conf++;
        if (!(host_req && host_lock)) begin
            m_locked = 0; m_streak = 0;
        end else if (w == 2) begin
            if (m_locked) m_streak = (m_streak < MAX_LOCK) ? m_streak + 1 : MAX_LOCK;
            else begin m_locked = 1; m_streak = 1; end
        end else if (w == 1 && m_locked) m_streak = 0;
        if (w != 0) m_last = w;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int hg, cg, between;
        checks = 0; failures = 0;
        set_idle();
        reset_n = 0;
        model_reset();
        @(posedge CLK); #1;
        run_cycle();
        reset_n = 1;
        run_cycle();

        // Both requesting every cycle without lock: strict alternation, core first
        core_req = 1; host_req = 1;
        for (int i = 0; i < 8; i++) begin
            core_we = 1'($urandom); core_addr = 8'($urandom_range(64, 127)); core_wdata = 8'($urandom);
            host_we = 1'($urandom); host_addr = 8'($urandom_range(64, 127)); host_wdata = 8'($urandom);
            run_cycle();
            chk("alternate", 32'(g_core), 32'(i % 2 == 0));
        end

        // Core only: store then load the same word
        set_idle();
        core_req = 1; core_we = 1; core_addr = 8'h10; core_wdata = 8'h5A;
        run_cycle();
        core_we = 0; core_wdata = 8'h00;
        run_cycle();
        set_idle();
        chk("t1_rvalid", 32'(core_rvalid), 32'(1));
        chk("t1_rdata", 32'(core_rdata), 32'h5A);
        run_cycle();
        chk("t1_rvalid_drop", 32'(core_rvalid), 32'(0));

        // Host store wins the same-address race; core load then sees it
        core_req = 1; core_we = 1; core_addr = 8'h30; core_wdata = 8'h11;
        run_cycle();
        core_we = 0; core_addr = 8'h20;
        host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'hA5;
        run_cycle();
        chk("t4_host_first", 32'(g_host), 32'(1));
        host_req = 0;
        run_cycle();
        set_idle();
        chk("t4_rdata", 32'(core_rdata), 32'hA5);

        // Locked host burst of 40 stores with core store held: fairness slot every 16 host grants
        host_req = 1; host_we = 1; host_lock = 1;
        host_addr = 8'h80; host_wdata = 8'($urandom);
        run_cycle();
        hg = 1; cg = 0; between = 0;
        core_req = 1; core_we = 1; core_addr = 8'h40; core_wdata = 8'h77;
        for (int c = 0; c < 200 && hg < 40; c++) begin
            host_addr = 8'($urandom_range(128, 191)); host_wdata = 8'($urandom);
            run_cycle();
            if (g_host) begin
                hg++;
                if (cg == 1) between++;
            end
            if (g_core) cg++;
        end
        chk("t3_host_grants", 32'(hg), 32'(40));
        chk("t3_core_grants", 32'(cg), 32'(2));
        chk("t3_between", 32'(between), 32'(16));

        // Reset during a locked host load: nothing returned, lock dropped
        core_req = 0; host_we = 0; host_addr = 8'h20;
        #1;
        reset_n = 0;
        set_idle();
        @(posedge CLK); #1;
        chk("t5_host_rvalid", 32'(host_rvalid), 32'(0));
        chk("t5_host_rdata", 32'(host_rdata), 32'(0));
        chk("t5_core_rdata", 32'(core_rdata), 32'(0));
        chk("t5_gnt", 32'({core_gnt, host_gnt, mem_we}), 32'(0));
        chk("t5_conflict", 32'(conflict_ct), 32'(0));
        model_reset();
        reset_n = 1;
        core_req = 1; host_req = 1; host_lock = 1; host_we = 1; host_addr = 8'h81; host_wdata = 8'h3C;
        core_we = 1; core_addr = 8'h41; core_wdata = 8'hC3;
        run_cycle();
        chk("t5_rr_after_reset", 32'(g_core), 32'(1));

        // Randomized traffic on a small address window
        set_idle();
        g_core = 0; g_host = 0;
        for (int c = 0; c < 400; c++) begin
            if (core_req && !g_core) begin
                if ($urandom_range(0, 7) == 0) core_req = 0;
            end else begin
                core_req = 1'($urandom); core_we = 1'($urandom);
                core_addr = 8'($urandom_range(0, 7)); core_wdata = 8'($urandom);
            end
            if (host_req && !g_host) begin
                if ($urandom_range(0, 7) == 0) host_req = 0;
            end else begin
                host_req = ($urandom_range(0, 3) != 0); host_we = 1'($urandom);
                host_addr = 8'($urandom_range(0, 7)); host_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 15) == 0) host_lock = ~host_lock;
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
